// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request and completion bus of the data memory responder
interface data_mem_responder_if;
    logic        read;
    logic        write;
    logic [31:0] d;
    logic [31:0] dataEN;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output read, write, d, dataEN,
        input  data, ready, busy, err
    );

    modport slave (
        input  read, write, d, dataEN,
        output data, ready, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency word-addressed data memory with error reporting
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_d;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic          w_accept;
    logic          w_fire;
    logic          w_reject;
    logic [AW-1:0] w_idx;

    assign w_idx    = r_d[AW+1:2];
    assign w_accept = (r_state == IDLE) && (bus.read || bus.write);
    assign w_fire   = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_reject = (r_d[1:0] != 2'b00)
                   || ({2'b00, r_d[31:2]} >= 32'(DEPTH))
                   || (r_rd && r_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.read || bus.write) w_next = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (r_state == DONE);
        bus.busy  = (r_state != IDLE);
        bus.err   = (r_state == DONE) && r_err;
        bus.data  = r_data;
    end

    // Request fields are captured once at acceptance; the bus is ignored afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_d     <= 32'd0;
            r_wdata <= 32'd0;
            r_data  <= 32'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            if (w_accept) begin
                r_rd    <= bus.read;
                r_wr    <= bus.write;
                r_d     <= bus.d;
                r_wdata <= bus.dataEN;
                r_cnt   <= 4'(LATENCY - 1);
                r_err   <= 1'b0;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_fire) begin
                r_err <= w_reject;
                if (w_reject) begin
                    r_data <= 32'd0;
                end else if (r_wr) begin
                    r_mem[w_idx] <= r_wdata;
                end else begin
                    r_data <= r_mem[w_idx];
                end
            end
        end
    end
endmodule
